pe_obuf_writer: RTL and testbench
=================================

// Module: pe_obuf_writer
// PURPOSE
//  Output-side partner of pe_array: captures each accumulated row (acc pulse + obuf_write_data), buffers it,
//  requantizes ACCU_WIDTH lanes to OUT_WIDTH, and writes the packed rows to the output buffer at sequential
//  addresses. Applies backpressure to the array via stall and reports layer completion with done.
// PARAMETERS
//  NUM_OUT_CHANNEL  8   lanes per row (matches pe_array ARRAY_M)
//  ACCU_WIDTH       24  signed accumulator width per lane
//  OUT_WIDTH        8   signed output width per lane after requantization
//  OBUF_ADDR_WIDTH  10  output buffer address width
//  FIFO_DEPTH       4   row FIFO entries, power of two, >=2
// PORTS
//  clk              in   1                          clock, all logic on posedge
//  reset            in   1                          synchronous, active-high
//  enable           in   1                          global enable; when low no push/pop/state change
//  start            in   1                          pulse: latch num_rows and shift, clear addr/counters/overflow
//  num_rows         in   OBUF_ADDR_WIDTH            rows to write this layer
//  shift            in   5                          requant arithmetic right shift, 0..ACCU_WIDTH-1
//  acc              in   1                          row valid from pe_array
//  obuf_write_data  in   NUM_OUT_CHANNEL*ACCU_WIDTH lane i at [i*ACCU_WIDTH +: ACCU_WIDTH]
//  obuf_wr_ready    in   1                          output buffer accepts a write this cycle
//  stall            out  1                          FIFO occupancy >= FIFO_DEPTH-1
//  obuf_wr_en       out  1                          write strobe
//  obuf_wr_addr     out  OBUF_ADDR_WIDTH            write address, 0..num_rows-1
//  obuf_wr_data     out  NUM_OUT_CHANNEL*OUT_WIDTH  lane i at [i*OUT_WIDTH +: OUT_WIDTH]
//  done             out  1                          one-cycle pulse after last row written
//  overflow         out  1                          sticky: acc arrived with FIFO full
// BEHAVIOUR
//  - Reset: state IDLE, FIFO empty, all outputs 0, latched num_rows/shift = 0.
//  - FSM: IDLE -start-> RUN (num_rows==0: -> DONE); RUN -last row pushed-> DRAIN;
//    DRAIN -last row written-> DONE; DONE -> IDLE (done=1 for exactly this cycle).
//  - start outside IDLE is ignored. acc outside RUN is ignored (no push, no overflow).
//  - Push: enable & acc & RUN & FIFO not full. Pushed-row counter ends RUN at num_rows.
//  - acc with FIFO full and no pop same cycle: row dropped, overflow<=1 until next accepted start or reset.
//    Full FIFO with simultaneous pop and push: both happen, no overflow.
//  - Pop: enable & FIFO not empty & (obuf_wr_en==0 | obuf_wr_ready). Popped row requantized into
//    output register; obuf_wr_en held with stable addr/data until obuf_wr_ready.
//  - Latency: acc at cycle t, FIFO empty, ready high -> obuf_wr_en=1 at t+2; sustained 1 row/cycle.
//  - obuf_wr_addr starts 0, increments on each accepted write (wr_en & ready), wraps mod 2^OBUF_ADDR_WIDTH.
//  - Requant per lane: r = (x + (shift? 1<<(shift-1) : 0)) >>> shift, computed at ACCU_WIDTH+1 bits;
//    saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
//  - enable low freezes FIFO, counters, FSM and output register; obuf_wr_en keeps its value.
//  - Reset mid-layer: FIFO flushed, in-flight write abandoned, no done pulse.
// CONFIGURATION
//  OBUF_RELU_EN defined: lanes with x<0 forced to 0 before requant (outputs in [0, 2^(OUT_WIDTH-1)-1]).
//  OBUF_RELU_EN undefined: signed requant/saturation only, negatives pass through.
// STRUCTURE
//  Shared package pe_array_pkg: ACCU_WIDTH/OUT_WIDTH defaults, writer state enum
//  (IDLE/RUN/DRAIN/DONE), sat_round function used by lane logic.
//  One sub-module: obuf_row_fifo (sync FIFO, width NUM_OUT_CHANNEL*ACCU_WIDTH, depth FIFO_DEPTH, count out).
// TESTING
//  1 start num_rows=3 shift=0, 3 back-to-back acc, lanes 5,-3,127,128,... ready=1 -> addrs 0,1,2,
//    lanes 5,-3,127,127(sat); first wr_en 2 cycles after first acc; done once after addr 2.
//  2 shift=4, lane 0x000018 (24) -> 2 (round half up); lane -24 -> -1; lane 0x7FFFFF -> 127.
//  3 ready=0 for 10 cycles, acc every cycle, FIFO_DEPTH=4 -> stall=1 at occupancy 3; 6th acc sets
//    overflow=1, row dropped; after ready=1 only accepted rows written, addr order preserved.
//  4 num_rows=0 start -> done pulse next-next cycle, no wr_en; acc in IDLE -> no write, overflow stays 0.
//  5 reset asserted mid-DRAIN with 2 rows queued -> next cycle wr_en=0, stall=0, FSM IDLE, no done.
//  6 OBUF_RELU_EN defined, lane -100 shift 0 -> 0; undefined -> -100 (0x9C).

Source files
------------

// File: rtl/pe_array_pkg.sv
// Shared types and helpers for the pe_array output path: writer FSM states and
// the per-lane round-half-up / saturate requantizer.
package pe_array_pkg;

    localparam int PKG_ACCU_WIDTH = 24;
    localparam int PKG_OUT_WIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wr_state_e;

    // Evaluated at 64 bits, so x + half never overflows for any accumulator
    // width this block is built with.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] x,
                                                     input logic [4:0]         sh,
                                                     input int                 out_w);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        r  = x;
        if (sh != 5'd0)
            r = r + (64'sd1 <<< (sh - 5'd1));
        r = r >>> sh;
        if (r > hi)
            r = hi;
        else if (r < lo)
            r = lo;
        return r;
    endfunction

endpackage

// File: rtl/obuf_row_fifo.sv
// Synchronous row FIFO with combinational head read and occupancy count.
// Caller never pushes into a full FIFO unless it pops in the same cycle.
module obuf_row_fifo #(
    parameter int WIDTH = 192,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Row storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/pe_obuf_writer.sv
// Buffers accumulated rows from pe_array, requantizes each lane and writes packed
// rows to the output buffer at sequential addresses. Build option: OBUF_RELU_EN.
module pe_obuf_writer
    import pe_array_pkg::*;
#(
    parameter int NUM_OUT_CHANNEL = 8,
    parameter int ACCU_WIDTH      = PKG_ACCU_WIDTH,
    parameter int OUT_WIDTH       = PKG_OUT_WIDTH,
    parameter int OBUF_ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  enable,
    input  logic                                  start,
    input  logic [OBUF_ADDR_WIDTH-1:0]            num_rows,
    input  logic [4:0]                            shift,
    input  logic                                  acc,
    input  logic [NUM_OUT_CHANNEL*ACCU_WIDTH-1:0] obuf_write_data,
    input  logic                                  obuf_wr_ready,
    output logic                                  stall,
    output logic                                  obuf_wr_en,
    output logic [OBUF_ADDR_WIDTH-1:0]            obuf_wr_addr,
    output logic [NUM_OUT_CHANNEL*OUT_WIDTH-1:0]  obuf_wr_data,
    output logic                                  done,
    output logic                                  overflow
);

    localparam int ROW_W = NUM_OUT_CHANNEL * ACCU_WIDTH;
    localparam int OUT_W = NUM_OUT_CHANNEL * OUT_WIDTH;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    wr_state_e                  r_state;
    logic [OBUF_ADDR_WIDTH-1:0] r_num_rows;
    logic [OBUF_ADDR_WIDTH-1:0] r_push_cnt;
    logic [OBUF_ADDR_WIDTH-1:0] r_wr_addr;
    logic [4:0]                 r_shift;
    logic                       r_wr_en;
    logic                       r_done;
    logic                       r_overflow;
    logic [OUT_W-1:0]           r_wr_data_p1;

    logic [ROW_W-1:0]           w_head_p0;
    logic [OUT_W-1:0]           w_q_p0;
    logic [CW-1:0]              w_count;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_acc_run;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_drop;
    logic                       w_wr_accept;
    logic [OBUF_ADDR_WIDTH-1:0] w_push_next;

    // A row leaves the FIFO whenever the output register is free or being emptied.
    assign w_wr_accept = r_wr_en & obuf_wr_ready;
    assign w_pop       = enable & ~w_empty & (~r_wr_en | obuf_wr_ready);
    assign w_acc_run   = enable & acc & (r_state == ST_RUN);
    assign w_push      = w_acc_run & (~w_full | w_pop);
    assign w_drop      = w_acc_run & w_full & ~w_pop;
    assign w_push_next = r_push_cnt + 1'b1;

    obuf_row_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (obuf_write_data),
        .o_rdata (w_head_p0),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // ---- stage p0: FIFO head -> requantized lanes ----
    for (genvar i = 0; i < NUM_OUT_CHANNEL; i++) begin : g_lane
        logic signed [ACCU_WIDTH-1:0] w_x;
`ifdef OBUF_RELU_EN
        assign w_x = w_head_p0[i*ACCU_WIDTH + ACCU_WIDTH-1] ? '0
                   : $signed(w_head_p0[i*ACCU_WIDTH +: ACCU_WIDTH]);
`else
        assign w_x = $signed(w_head_p0[i*ACCU_WIDTH +: ACCU_WIDTH]);
`endif
        assign w_q_p0[i*OUT_WIDTH +: OUT_WIDTH] =
            OUT_WIDTH'(sat_round(64'(w_x), r_shift, OUT_WIDTH));
    end

    // ---- stage p1: output register, write handshake, layer FSM ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_num_rows   <= '0;
            r_push_cnt   <= '0;
            r_wr_addr    <= '0;
            r_shift      <= '0;
            r_wr_en      <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_wr_data_p1 <= '0;
        end else begin
            r_done <= 1'b0;
            if (enable) begin
                if (w_pop) begin
                    r_wr_en      <= 1'b1;
                    r_wr_data_p1 <= w_q_p0;
                end else if (w_wr_accept) begin
                    r_wr_en <= 1'b0;
                end
                if (w_wr_accept)
                    r_wr_addr <= r_wr_addr + 1'b1;
                if (w_push)
                    r_push_cnt <= w_push_next;
                if (w_drop)
                    r_overflow <= 1'b1;

                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_num_rows <= num_rows;
                            r_shift    <= shift;
                            r_push_cnt <= '0;
                            r_wr_addr  <= '0;
                            r_overflow <= 1'b0;
                            r_state    <= (num_rows == '0) ? ST_DONE : ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (w_push && (w_push_next == r_num_rows))
                            r_state <= ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        if (w_empty && (!r_wr_en || obuf_wr_ready))
                            r_state <= ST_DONE;
                    end
                    ST_DONE: begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign stall        = (w_count >= CW'(FIFO_DEPTH - 1));
    assign obuf_wr_en   = r_wr_en;
    assign obuf_wr_addr = r_wr_addr;
    assign obuf_wr_data = r_wr_data_p1;
    assign done         = r_done;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_pe_obuf_writer.sv
// Directed bench for pe_obuf_writer; expectations follow OBUF_RELU_EN when defined.
module tb_pe_obuf_writer;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         start;
    logic [9:0]   num_rows;
    logic [4:0]   shift;
    logic         acc;
    logic [191:0] obuf_write_data;
    logic         obuf_wr_ready;
    logic         stall;
    logic         obuf_wr_en;
    logic [9:0]   obuf_wr_addr;
    logic [63:0]  obuf_wr_data;
    logic         done;
    logic         overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    logic [9:0]  q_addr [$];
    logic [63:0] q_data [$];

    pe_obuf_writer dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .start           (start),
        .num_rows        (num_rows),
        .shift           (shift),
        .acc             (acc),
        .obuf_write_data (obuf_write_data),
        .obuf_wr_ready   (obuf_wr_ready),
        .stall           (stall),
        .obuf_wr_en      (obuf_wr_en),
        .obuf_wr_addr    (obuf_wr_addr),
        .obuf_wr_data    (obuf_wr_data),
        .done            (done),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && enable && obuf_wr_en && obuf_wr_ready) begin
            q_addr.push_back(obuf_wr_addr);
            q_data.push_back(obuf_wr_data);
        end
        if (done)
            done_cnt++;
    end

    function automatic logic [191:0] pack_in(input int v [8]);
        logic [191:0] r;
        for (int i = 0; i < 8; i++) r[i*24 +: 24] = v[i][23:0];
        return r;
    endfunction

    function automatic logic [63:0] pack_out(input int v [8]);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = v[i][7:0];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int rows, input int sh);
        start    = 1'b1;
        num_rows = rows[9:0];
        shift    = sh[4:0];
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input string name);
        int k;
        k = 0;
        while (done_cnt == base && k < 40) begin
            step();
            k++;
        end
        n_tests++;
        if (done_cnt == base) begin
            n_fail++;
            $display("FAIL %s: done timeout, done_cnt=%0d required >%0d", name, done_cnt, base);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; start = 1'b0; num_rows = '0; shift = '0;
        acc = 1'b0; obuf_write_data = '0; obuf_wr_ready = 1'b1;
        step(); step();
        n_tests++;
        if ({obuf_wr_en, stall, done, overflow} !== 4'b0 || obuf_wr_addr !== 10'd0 || obuf_wr_data !== 64'd0) begin
            n_fail++;
            $display("FAIL reset: en=%b stall=%b done=%b ovf=%b addr=%0d data=%h required all 0",
                     obuf_wr_en, stall, done, overflow, obuf_wr_addr, obuf_wr_data);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int in_l [8];
        int ex_l [8];
        int base;
        in_l = '{5, -3, 127, 128, -128, -129, 0, 1000};
`ifdef OBUF_RELU_EN
        ex_l = '{5, 0, 127, 127, 0, 0, 0, 127};
`else
        ex_l = '{5, -3, 127, 127, -128, -128, 0, 127};
`endif
        q_addr.delete(); q_data.delete();
        base = done_cnt;
        obuf_wr_ready = 1'b1;
        do_start(3, 0);
        for (int r = 0; r < 3; r++) begin
            in_l[0] = 5 + r;
            obuf_write_data = pack_in(in_l);
            acc = 1'b1;
            step();
            if (r == 0) begin
                n_tests++;
                if (obuf_wr_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_lat1: wr_en=%b required 0", obuf_wr_en);
                end
            end
            if (r == 1) begin
                n_tests++;
                if (obuf_wr_en !== 1'b1 || obuf_wr_addr !== 10'd0) begin
                    n_fail++;
                    $display("FAIL basic_lat2: wr_en=%b addr=%0d required 1,0", obuf_wr_en, obuf_wr_addr);
                end
            end
        end
        acc = 1'b0;
        wait_done(base, "basic");
        step(); step();
        n_tests++;
        if (q_addr.size() != 3) begin
            n_fail++;
            $display("FAIL basic_count: writes=%0d required 3", q_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                ex_l[0] = 5 + i;
                n_tests++;
                if (q_addr[i] !== 10'(i) || q_data[i] !== pack_out(ex_l)) begin
                    n_fail++;
                    $display("FAIL basic_row%0d: addr=%0d data=%h required addr=%0d data=%h",
                             i, q_addr[i], q_data[i], i, pack_out(ex_l));
                end
            end
        end
        n_tests++;
        if (done_cnt - base != 1) begin
            n_fail++;
            $display("FAIL basic_done: pulses=%0d required 1", done_cnt - base);
        end
    endtask

    task automatic test_round();
        int in_l [8];
        int ex_l [8];
        int base;
        in_l = '{24, -24, 32'h7FFFFF, -8388608, 7, 8, -8, -9};
`ifdef OBUF_RELU_EN
        ex_l = '{2, 0, 127, 0, 0, 1, 0, 0};
`else
        ex_l = '{2, -1, 127, -128, 0, 1, 0, -1};
`endif
        q_addr.delete(); q_data.delete();
        base = done_cnt;
        do_start(1, 4);
        obuf_write_data = pack_in(in_l);
        acc = 1'b1;
        step();
        acc = 1'b0;
        wait_done(base, "round");
        n_tests++;
        if (q_data.size() != 1 || q_data[0] !== pack_out(ex_l) || q_addr[0] !== 10'd0) begin
            n_fail++;
            $display("FAIL round: writes=%0d data=%h required 1 write data=%h",
                     q_data.size(), (q_data.size() > 0) ? q_data[0] : 64'd0, pack_out(ex_l));
        end
    endtask

    task automatic test_backpressure();
        int in_l [8];
        int ex_l [8];
        int exp0 [6];
        int base;
        in_l = '{0, 0, 0, 0, 0, 0, 0, 0};
        ex_l = '{0, 0, 0, 0, 0, 0, 0, 0};
        exp0 = '{1, 2, 3, 4, 5, 11};
        q_addr.delete(); q_data.delete();
        base = done_cnt;
        obuf_wr_ready = 1'b0;
        do_start(6, 0);
        for (int k = 1; k <= 10; k++) begin
            in_l[0] = k;
            obuf_write_data = pack_in(in_l);
            acc = 1'b1;
            step();
            if (k == 2) begin
                n_tests++;
                if (obuf_wr_en !== 1'b1 || obuf_wr_addr !== 10'd0) begin
                    n_fail++;
                    $display("FAIL bp_hold: wr_en=%b addr=%0d required 1,0", obuf_wr_en, obuf_wr_addr);
                end
            end
            if (k == 3 || k == 4) begin
                n_tests++;
                if (stall !== (k == 4)) begin
                    n_fail++;
                    $display("FAIL bp_stall_k%0d: stall=%b required %b", k, stall, (k == 4));
                end
            end
            if (k == 5 || k == 6) begin
                n_tests++;
                if (overflow !== (k == 6)) begin
                    n_fail++;
                    $display("FAIL bp_ovf_k%0d: overflow=%b required %b", k, overflow, (k == 6));
                end
            end
        end
        acc = 1'b0;
        n_tests++;
        if (q_addr.size() != 0) begin
            n_fail++;
            $display("FAIL bp_nowrite: writes=%0d required 0", q_addr.size());
        end
        obuf_wr_ready = 1'b1;
        step(); step(); step();
        in_l[0] = 11;
        obuf_write_data = pack_in(in_l);
        acc = 1'b1;
        step();
        acc = 1'b0;
        wait_done(base, "bp");
        n_tests++;
        if (q_addr.size() != 6) begin
            n_fail++;
            $display("FAIL bp_count: writes=%0d required 6", q_addr.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                ex_l[0] = exp0[i];
                n_tests++;
                if (q_addr[i] !== 10'(i) || q_data[i] !== pack_out(ex_l)) begin
                    n_fail++;
                    $display("FAIL bp_row%0d: addr=%0d data=%h required addr=%0d data=%h",
                             i, q_addr[i], q_data[i], i, pack_out(ex_l));
                end
            end
        end
        n_tests++;
        if (overflow !== 1'b1 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end: overflow=%b stall=%b required 1,0", overflow, stall);
        end
    endtask

    task automatic test_zero_rows();
        int base;
        q_addr.delete(); q_data.delete();
        base = done_cnt;
        do_start(0, 0);
        n_tests++;
        if (done !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_t1: done=%b overflow=%b required 0,0", done, overflow);
        end
        step();
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_t2: done=%b required 1", done);
        end
        step();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_t3: done=%b required 0", done);
        end
        obuf_write_data = '1;
        acc = 1'b1;
        step(); step(); step();
        acc = 1'b0;
        step(); step();
        n_tests++;
        if (q_addr.size() != 0 || obuf_wr_en !== 1'b0 || overflow !== 1'b0 || done_cnt - base != 1) begin
            n_fail++;
            $display("FAIL zero_idle_acc: writes=%0d wr_en=%b ovf=%b done_pulses=%0d required 0,0,0,1",
                     q_addr.size(), obuf_wr_en, overflow, done_cnt - base);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        q_addr.delete(); q_data.delete();
        obuf_wr_ready = 1'b0;
        do_start(3, 0);
        for (int k = 0; k < 3; k++) begin
            obuf_write_data = 192'(k + 1);
            acc = 1'b1;
            step();
        end
        acc = 1'b0;
        n_tests++;
        if (obuf_wr_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: wr_en=%b required 1", obuf_wr_en);
        end
        base = done_cnt;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_tests++;
        if (obuf_wr_en !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_post: wr_en=%b stall=%b required 0,0", obuf_wr_en, stall);
        end
        obuf_wr_ready = 1'b1;
        for (int k = 0; k < 5; k++) step();
        n_tests++;
        if (done_cnt != base || q_addr.size() != 0) begin
            n_fail++;
            $display("FAIL rst_quiet: done_pulses=%0d writes=%0d required 0,0", done_cnt - base, q_addr.size());
        end
        do_start(0, 0);
        step();
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_idle: done=%b required 1 (start accepted from IDLE)", done);
        end
        step();
    endtask

    task automatic test_relu();
        int in_l [8];
        int ex_l [8];
        int base;
        in_l = '{-100, 100, -1, 50, 0, -128, 127, -7};
`ifdef OBUF_RELU_EN
        ex_l = '{0, 100, 0, 50, 0, 0, 127, 0};
`else
        ex_l = '{-100, 100, -1, 50, 0, -128, 127, -7};
`endif
        q_addr.delete(); q_data.delete();
        base = done_cnt;
        do_start(1, 0);
        obuf_write_data = pack_in(in_l);
        acc = 1'b1;
        step();
        acc = 1'b0;
        wait_done(base, "relu");
        n_tests++;
        if (q_data.size() != 1 || q_data[0] !== pack_out(ex_l)) begin
            n_fail++;
            $display("FAIL relu: writes=%0d data=%h required 1 write data=%h",
                     q_data.size(), (q_data.size() > 0) ? q_data[0] : 64'd0, pack_out(ex_l));
        end
    endtask

    task automatic test_enable();
        int in_l [8];
        int ex_l [8];
        int base;
        in_l = '{42, 0, 0, 0, 0, 0, 0, 0};
        ex_l = '{42, 0, 0, 0, 0, 0, 0, 0};
        q_addr.delete(); q_data.delete();
        base = done_cnt;
        do_start(1, 0);
        enable = 1'b0;
        obuf_write_data = pack_in(in_l);
        acc = 1'b1;
        step(); step(); step();
        n_tests++;
        if (obuf_wr_en !== 1'b0 || q_addr.size() != 0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_freeze: wr_en=%b writes=%0d stall=%b required 0,0,0",
                     obuf_wr_en, q_addr.size(), stall);
        end
        enable = 1'b1;
        step();
        acc = 1'b0;
        wait_done(base, "enable");
        n_tests++;
        if (q_data.size() != 1 || q_data[0] !== pack_out(ex_l)) begin
            n_fail++;
            $display("FAIL enable_row: writes=%0d required 1 write data=%h", q_data.size(), pack_out(ex_l));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round();
        test_backpressure();
        test_zero_rows();
        test_reset_mid();
        test_relu();
        test_enable();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
